param_commit_ctrl: RTL and testbench

//  Sequences updates of the HSV threshold parameters from the AXI4-Lite parameter register bank into
//  the pixel pipeline. The shadow words are snapshotted on a software commit request. They are applied

---
 rtl/param_commit_ctrl.sv | 172 +++++++++++++++++
 tb/tb_param_commit_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_commit_ctrl.sv
// param_commit_ctrl
//   Moves HSV threshold words from the register bank into the pixel datapath
//   so that a new parameter set takes effect only at a frame boundary.
//   A rising edge on commit_req_i snapshots shadow_i into staging. The
//   following start of frame copies staging into active_o in one cycle.
//
// Optional feature (macro COMMIT_TIMEOUT_EN):
//   A pending commit that sees no start of frame for TIMEOUT_CYC cycles is
//   applied anyway, and timeout_o flags that this happened. When the macro is
//   undefined, no counter is built and timeout_o is tied to 0.
//
// Ports
//   ACLK, ARESETN     clock and asynchronous active-low reset
//   shadow_i          live register-bank words; word k sits at [k*DATA_W +: DATA_W]
//   commit_req_i      commit level; a 0->1 edge requests a snapshot
//   sof_i             one-cycle start-of-frame strobe
//   active_o          words driven into the HSV datapath
//   update_o          pulses in the cycle active_o takes new values
//   commit_pending_o  a snapshot is waiting for start of frame
//   frame_cnt_o       free-running count of sof_i pulses, wraps to 0
//   timeout_o         sticky: the last commit was forced by the timeout

// One parameter word: its staging copy and the active copy it feeds.
module param_word #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap,
  input  logic              load,
  input  logic              load_shadow,
  input  logic [DATA_W-1:0] shadow,
  output logic [DATA_W-1:0] active
);
  logic [DATA_W-1:0] staging;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= RST_VAL;
      active  <= RST_VAL;
    end else begin
      if (snap) staging <= shadow;
      // A snapshot taken in the same cycle as the apply bypasses staging,
      // so the freshest words land in active.
      if (load) active <= load_shadow ? shadow : staging;
    end
  end
endmodule

module param_commit_ctrl #(
  parameter int                NUM_REGS    = 4,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RST_VAL     = '0,
  parameter int                FCNT_W      = 16,
  parameter int                TIMEOUT_CYC = 1048576
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [NUM_REGS*DATA_W-1:0] shadow_i,
  input  logic                       commit_req_i,
  input  logic                       sof_i,
  output logic [NUM_REGS*DATA_W-1:0] active_o,
  output logic                       update_o,
  output logic                       commit_pending_o,
  output logic [FCNT_W-1:0]          frame_cnt_o,
  output logic                       timeout_o
);
  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

  state_t state, state_nxt;
  logic   commit_req_q;
  logic   req_rise;
  logic   snap;
  logic   load;
  logic   tmo_fire;
  logic   tmo_hit;

  assign req_rise = commit_req_i & ~commit_req_q;
  // Entering APPLY is what loads active, so active_o and update_o change on
  // the same edge, one cycle after the triggering sof_i.
  assign load     = (state_nxt == APPLY);

  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: begin
        // sof_i in this cycle is ignored: the new snapshot waits a frame.
        if (req_rise) begin
          snap      = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        snap = req_rise;
        if (sof_i) begin
          state_nxt = APPLY;
        end else if (!req_rise && tmo_hit) begin
          state_nxt = APPLY;
          tmo_fire  = 1'b1;
        end
      end
      APPLY: begin
        if (req_rise) begin
          snap      = 1'b1;
          state_nxt = ARMED;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state            <= IDLE;
      commit_req_q     <= 1'b0;
      update_o         <= 1'b0;
      commit_pending_o <= 1'b0;
      frame_cnt_o      <= '0;
    end else begin
      state            <= state_nxt;
      commit_req_q     <= commit_req_i;
      update_o         <= load;
      commit_pending_o <= (state_nxt == ARMED);
      if (sof_i) frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
    end
  end

`ifdef COMMIT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tcnt;
  logic          tmo_q;

  assign tmo_hit   = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_o = tmo_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      // Counts ARMED cycles since entry or the latest re-snapshot.
      if (state == ARMED && state_nxt == ARMED && !snap) tcnt <= tcnt + TW'(1);
      else                                              tcnt <= '0;
      // Every apply rewrites the flag: set when forced, cleared by sof_i.
      if (load) tmo_q <= tmo_fire;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_word
    param_word #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_word (
      .clk         (ACLK),
      .rst_n       (ARESETN),
      .snap        (snap),
      .load        (load),
      .load_shadow (snap),
      .shadow      (shadow_i[k*DATA_W +: DATA_W]),
      .active      (active_o[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_param_commit_ctrl.sv
// Directed bench for param_commit_ctrl: reset, basic commit, snapshot
// isolation, request/sof coincidence, reset mid-commit, frame counter wrap,
// and the optional timeout path.
module tb_param_commit_ctrl;
  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;
  localparam int FCNT_W   = 4;
  localparam int TMO      = 8;

  logic                       ACLK = 1'b0;
  logic                       ARESETN;
  logic [NUM_REGS*DATA_W-1:0] shadow_i;
  logic                       commit_req_i;
  logic                       sof_i;
  logic [NUM_REGS*DATA_W-1:0] active_o;
  logic                       update_o;
  logic                       commit_pending_o;
  logic [FCNT_W-1:0]          frame_cnt_o;
  logic                       timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  param_commit_ctrl #(
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (DATA_W),
    .RST_VAL     (32'h0),
    .FCNT_W      (FCNT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .shadow_i         (shadow_i),
    .commit_req_i     (commit_req_i),
    .sof_i            (sof_i),
    .active_o         (active_o),
    .update_o         (update_o),
    .commit_pending_o (commit_pending_o),
    .frame_cnt_o      (frame_cnt_o),
    .timeout_o        (timeout_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [127:0] w4(input logic [31:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  initial begin
    ARESETN = 1'b0; shadow_i = w4(32'h4, 32'h3, 32'h2, 32'h1);
    commit_req_i = 1'b0; sof_i = 1'b0;

    // T1: reset holds everything regardless of sof/commit activity
    for (int i = 0; i < 4; i++) begin
      sof_i = i[0]; commit_req_i = ~i[0];
      step();
    end
    chk("rst_active",  active_o, '0);
    chk("rst_update",  update_o, 1'b0);
    chk("rst_fcnt",    frame_cnt_o, 4'd0);
    chk("rst_pending", commit_pending_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    sof_i = 1'b0; commit_req_i = 1'b0;
    step();
    ARESETN = 1'b1;
    step();

    // T2: basic commit, pending for 10 cycles, applied the cycle after sof
    commit_req_i = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t2_pending", commit_pending_o, 1'b1);
      chk("t2_noupd",   update_o, 1'b0);
      if (i < 9) step();
    end
    chk("t2_active_hold", active_o, '0);
    sof_i = 1'b1;
    step();
    sof_i = 1'b0;
    chk("t2_update",  update_o, 1'b1);
    chk("t2_active",  active_o, w4(32'h4, 32'h3, 32'h2, 32'h1));
    chk("t2_pend0",   commit_pending_o, 1'b0);
    chk("t2_fcnt",    frame_cnt_o, 4'd1);
    commit_req_i = 1'b0;
    step();
    chk("t2_upd_pulse", update_o, 1'b0);

    // T3: shadow change after snapshot must not leak into active
    commit_req_i = 1'b1;
    step();
    shadow_i = w4(32'h4, 32'h3, 32'h2, 32'hDEAD);
    step(); step();
    sof_i = 1'b1;
    step();
    sof_i = 1'b0; commit_req_i = 1'b0;
    chk("t3_update", update_o, 1'b1);
    chk("t3_word0",  active_o[31:0], 32'h1);
    step();
    chk("t3_hold",   active_o, w4(32'h4, 32'h3, 32'h2, 32'h1));
    chk("t3_fcnt",   frame_cnt_o, 4'd2);

    // T4a: req_rise with sof in IDLE does not apply until the next sof
    shadow_i = w4(32'h8, 32'h7, 32'h6, 32'h5);
    commit_req_i = 1'b1; sof_i = 1'b1;
    step();
    sof_i = 1'b0;
    chk("t4a_noupd",   update_o, 1'b0);
    chk("t4a_pending", commit_pending_o, 1'b1);
    chk("t4a_old",     active_o, w4(32'h4, 32'h3, 32'h2, 32'h1));
    step();
    sof_i = 1'b1;
    step();
    sof_i = 1'b0; commit_req_i = 1'b0;
    chk("t4a_update",  update_o, 1'b1);
    chk("t4a_active",  active_o, w4(32'h8, 32'h7, 32'h6, 32'h5));
    step();

    // T4b: req_rise together with sof in ARMED applies the new snapshot
    shadow_i = w4(32'h14, 32'h13, 32'h12, 32'h11);
    commit_req_i = 1'b1;
    step();
    commit_req_i = 1'b0;
    step();
    shadow_i = w4(32'h24, 32'h23, 32'h22, 32'h21);
    commit_req_i = 1'b1; sof_i = 1'b1;
    step();
    sof_i = 1'b0; commit_req_i = 1'b0;
    chk("t4b_update", update_o, 1'b1);
    chk("t4b_active", active_o, w4(32'h24, 32'h23, 32'h22, 32'h21));
    step();
    chk("t4b_idle",   commit_pending_o, 1'b0);
    chk("t4b_fcnt",   frame_cnt_o, 4'd5);

    // Reset mid-commit discards the snapshot and clears active at once
    commit_req_i = 1'b1;
    step();
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_active",  active_o, '0);
    chk("mid_rst_pending", commit_pending_o, 1'b0);
    commit_req_i = 1'b0;
    step();
    ARESETN = 1'b1;
    step();

    // T5: 17 sof pulses on a 4-bit counter wrap to 1; no stale apply
    for (int i = 0; i < 17; i++) begin
      sof_i = 1'b1; step();
      sof_i = 1'b0; step();
    end
    chk("t5_fcnt",   frame_cnt_o, 4'd1);
    chk("t5_active", active_o, '0);

    // T6: timeout path
    shadow_i = w4(32'h34, 32'h33, 32'h32, 32'h31);
    commit_req_i = 1'b1;
    step();
`ifdef COMMIT_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("t6_wait_noupd", update_o, 1'b0);
    end
    step();
    chk("t6_update",  update_o, 1'b1);
    chk("t6_timeout", timeout_o, 1'b1);
    chk("t6_active",  active_o, w4(32'h34, 32'h33, 32'h32, 32'h31));
    commit_req_i = 1'b0;
    step();
    chk("t6_sticky",  timeout_o, 1'b1);
    shadow_i = w4(32'h44, 32'h43, 32'h42, 32'h41);
    commit_req_i = 1'b1;
    step();
    sof_i = 1'b1;
    step();
    sof_i = 1'b0;
    chk("t6_sof_upd", update_o, 1'b1);
    chk("t6_cleared", timeout_o, 1'b0);
    chk("t6_active2", active_o, w4(32'h44, 32'h43, 32'h42, 32'h41));
`else
    for (int i = 0; i < 3 * TMO; i++) step();
    chk("t6_still_pending", commit_pending_o, 1'b1);
    chk("t6_noupd",         update_o, 1'b0);
    chk("t6_timeout0",      timeout_o, 1'b0);
    sof_i = 1'b1;
    step();
    sof_i = 1'b0;
    chk("t6_sof_upd", update_o, 1'b1);
    chk("t6_active",  active_o, w4(32'h34, 32'h33, 32'h32, 32'h31));
`endif
    commit_req_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
